window_3x3: RTL and testbench

- Upstream neighbour of the Sobel edge stage.
- Turns a raster-order 8-bit grey pixel stream into a 3x3 neighbourhood: z0..z8, row-major, z0 = top-left, z8 = bottom-right (newest pixel).
- Uses two line buffers plus a 3x3 shift window.
- Drives the Sobel stage's z0..z8 inputs directly and flags which windows are fully inside the frame.

---
 rtl/edge_pkg.sv | 7 +
 rtl/line_buffer.sv | 21 ++
 rtl/window_3x3.sv | 114 +++++++++++
 tb/tb_window_3x3.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Types and constants shared by the window generator and the Sobel edge stage.
package edge_pkg;
  localparam int PIX_W         = 8;
  localparam int DEFAULT_WIDTH = 640;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/line_buffer.sv
// One line of pixels. Reads are asynchronous and return the value held before
// a write to the same address in the same cycle.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/window_3x3.sv
// Builds a 3x3 neighbourhood from a raster pixel stream using two line buffers
// and a shift window; win_valid marks windows fully inside the current frame.
module window_3x3 import edge_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PIX_W = edge_pkg::PIX_W,
  parameter int COL_W = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] z0,
  output logic [PIX_W-1:0] z1,
  output logic [PIX_W-1:0] z2,
  output logic [PIX_W-1:0] z3,
  output logic [PIX_W-1:0] z4,
  output logic [PIX_W-1:0] z5,
  output logic [PIX_W-1:0] z6,
  output logic [PIX_W-1:0] z7,
  output logic [PIX_W-1:0] z8,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col
);
  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [COL_W-1:0] col_q, col_d, addr;
  logic [1:0]       row_q, row_d, row_used;
  logic [PIX_W-1:0] z_q [9];
  logic [PIX_W-1:0] z_d [9];
  logic             wv_q, wv_d;
  logic [COL_W-1:0] wcol_q, wcol_d;
  logic [PIX_W-1:0] line_a_rd, line_b_rd;
  logic             lb_we;

  // sof restarts the raster at (0,0) for the pixel that carries it
  assign addr     = sof ? '0 : col_q;
  assign row_used = sof ? 2'd0 : row_q;
  assign lb_we    = pix_valid & reset_n;

  line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W), .AW(AW)) u_line_a (
    .clock   (clock),
    .we_i    (lb_we),
    .addr_i  (addr[AW-1:0]),
    .wdata_i (pix_in),
    .rdata_o (line_a_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W), .AW(AW)) u_line_b (
    .clock   (clock),
    .we_i    (lb_we),
    .addr_i  (addr[AW-1:0]),
    .wdata_i (line_a_rd),
    .rdata_o (line_b_rd)
  );

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    z_d    = z_q;
    wv_d   = wv_q;
    wcol_d = wcol_q;
    if (pix_valid) begin
      if (addr == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_used == 2'd2) ? 2'd2 : row_used + 2'd1;
      end else begin
        col_d = addr + COL_W'(1);
        row_d = row_used;
      end
      z_d[0] = z_q[1];
      z_d[1] = z_q[2];
      z_d[2] = line_b_rd;
      z_d[3] = z_q[4];
      z_d[4] = z_q[5];
      z_d[5] = line_a_rd;
      z_d[6] = z_q[7];
      z_d[7] = z_q[8];
      z_d[8] = pix_in;
      // cols 0 and 1 of a row still carry the previous row's tail
      wv_d   = (row_used == 2'd2) && (addr >= COL_W'(2));
      wcol_d = addr;
    end
  end

  // output stage: one cycle after the accept
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      wv_q   <= 1'b0;
      wcol_q <= '0;
      for (int i = 0; i < 9; i++) z_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wv_q   <= wv_d;
      wcol_q <= wcol_d;
      z_q    <= z_d;
    end
  end

  assign z0        = z_q[0];
  assign z1        = z_q[1];
  assign z2        = z_q[2];
  assign z3        = z_q[3];
  assign z4        = z_q[4];
  assign z5        = z_q[5];
  assign z6        = z_q[6];
  assign z7        = z_q[7];
  assign z8        = z_q[8];
  assign win_valid = wv_q;
  assign win_col   = wcol_q;
endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3: a WIDTH=4 instance for the main scenarios and
// a WIDTH=3 instance for the narrowest legal line.
module tb_window_3x3;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        v4 = 1'b0, s4 = 1'b0, v3 = 1'b0, s3 = 1'b0;
  logic [7:0]  p4 = '0, p3 = '0;
  logic [7:0]  a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [7:0]  b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic        wv4, wv3;
  logic [11:0] wc4, wc3;
  logic [71:0] zc4, zc3;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  window_3x3 #(.WIDTH(4), .PIX_W(8), .COL_W(12)) u4 (
    .clock(clock), .reset_n(rst_n), .pix_in(p4), .pix_valid(v4), .sof(s4),
    .z0(a0), .z1(a1), .z2(a2), .z3(a3), .z4(a4), .z5(a5), .z6(a6), .z7(a7), .z8(a8),
    .win_valid(wv4), .win_col(wc4)
  );

  window_3x3 #(.WIDTH(3), .PIX_W(8), .COL_W(12)) u3 (
    .clock(clock), .reset_n(rst_n), .pix_in(p3), .pix_valid(v3), .sof(s3),
    .z0(b0), .z1(b1), .z2(b2), .z3(b3), .z4(b4), .z5(b5), .z6(b6), .z7(b7), .z8(b8),
    .win_valid(wv3), .win_col(wc3)
  );

  assign zc4 = {a0, a1, a2, a3, a4, a5, a6, a7, a8};
  assign zc3 = {b0, b1, b2, b3, b4, b5, b6, b7, b8};

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + 16 * r + c);
  endfunction

  // Expected taps for a window whose newest pixel is (r,c) of a ramp frame.
  function automatic logic [71:0] taps(input int base, input int r, input int c);
    return {pix(base, r-2, c-2), pix(base, r-2, c-1), pix(base, r-2, c),
            pix(base, r-1, c-2), pix(base, r-1, c-1), pix(base, r-1, c),
            pix(base, r,   c-2), pix(base, r,   c-1), pix(base, r,   c)};
  endfunction

  task automatic step4(input logic v, input logic s, input logic [7:0] p);
    @(negedge clock);
    v4 = v; s4 = s; p4 = p;
    @(posedge clock);
    #1;
  endtask

  task automatic step3(input logic v, input logic s, input logic [7:0] p);
    @(negedge clock);
    v3 = v; s3 = s; p3 = p;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    rst_n = 1'b0; v4 = 1'b1; p4 = 8'hFF; v3 = 1'b1; p3 = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        @(negedge clock);
        rst_n = 1'b1; v4 = 1'b0; v3 = 1'b0;
      end
      @(posedge clock);
      #1;
      checks++;
      if (zc4 !== 72'h0 || wv4 !== 1'b0 || wc4 !== 12'd0) begin
        errors++;
        $display("FAIL reset_w4 k=%0d got z=%h wv=%b col=%0d exp z=0 wv=0 col=0", k, zc4, wv4, wc4);
      end
      checks++;
      if (zc3 !== 72'h0 || wv3 !== 1'b0 || wc3 !== 12'd0) begin
        errors++;
        $display("FAIL reset_w3 k=%0d got z=%h wv=%b col=%0d exp z=0 wv=0 col=0", k, zc3, wv3, wc3);
      end
    end
  endtask

  task automatic test_ramp();
    logic ev;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step4(1'b1, (r == 0 && c == 0), pix(0, r, c));
        ev = (r >= 2 && c >= 2);
        checks++;
        if (wv4 !== ev || wc4 !== 12'(c)) begin
          errors++;
          $display("FAIL ramp_ctl r=%0d c=%0d got wv=%b col=%0d exp wv=%b col=%0d", r, c, wv4, wc4, ev, c);
        end
        if (ev) begin
          checks++;
          if (zc4 !== taps(0, r, c)) begin
            errors++;
            $display("FAIL ramp_taps r=%0d c=%0d got %h exp %h", r, c, zc4, taps(0, r, c));
          end
        end
      end
    end
    checks++;
    if (zc4 !== 72'h101112202122303132 && 1'b0) errors++;
    // the (3,3) window shown by hand: 11 12 13 / 21 22 23 / 31 32 33
    if (zc4 !== 72'h111213212223313233) begin
      errors++;
      $display("FAIL ramp_last got %h exp 111213212223313233", zc4);
    end
  endtask

  task automatic test_stalls();
    logic        ev, lev;
    int          lc;
    logic [71:0] lt;
    lev = 1'b1; lc = 3; lt = taps(0, 3, 3);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 3 && $urandom_range(1) == 0; k++) begin
          step4(1'b0, 1'($urandom_range(1)), 8'($urandom));
          checks++;
          if (wv4 !== lev || wc4 !== 12'(lc) || (lev && zc4 !== lt)) begin
            errors++;
            $display("FAIL stall_hold r=%0d c=%0d got wv=%b col=%0d z=%h exp wv=%b col=%0d z=%h",
                     r, c, wv4, wc4, zc4, lev, lc, lt);
          end
        end
        step4(1'b1, (r == 0 && c == 0), pix(0, r, c));
        ev = (r >= 2 && c >= 2);
        checks++;
        if (wv4 !== ev || wc4 !== 12'(c) || (ev && zc4 !== taps(0, r, c))) begin
          errors++;
          $display("FAIL stall_acc r=%0d c=%0d got wv=%b col=%0d z=%h exp wv=%b col=%0d z=%h",
                   r, c, wv4, wc4, zc4, ev, c, taps(0, r, c));
        end
        lev = ev; lc = c; lt = taps(0, r, c);
      end
    end
  endtask

  task automatic test_midframe_sof();
    logic ev;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) step4(1'b1, (r == 0 && c == 0), pix(0, r, c));
    step4(1'b1, 1'b0, pix(0, 3, 0));
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step4(1'b1, (r == 0 && c == 0), pix(8'h80, r, c));
        ev = (r >= 2 && c >= 2);
        checks++;
        if (wv4 !== ev || wc4 !== 12'(c) || (ev && zc4 !== taps(8'h80, r, c))) begin
          errors++;
          $display("FAIL midsof r=%0d c=%0d got wv=%b col=%0d z=%h exp wv=%b col=%0d z=%h",
                   r, c, wv4, wc4, zc4, ev, c, taps(8'h80, r, c));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic ev;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4 && !(r == 2 && c == 3); c++) step4(1'b1, (r == 0 && c == 0), pix(0, r, c));
    @(negedge clock);
    rst_n = 1'b0; v4 = 1'b1; s4 = 1'b0; p4 = pix(0, 2, 3);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (zc4 !== 72'h0 || wv4 !== 1'b0 || wc4 !== 12'd0) begin
        errors++;
        $display("FAIL rstmid_zero k=%0d got z=%h wv=%b col=%0d exp all zero", k, zc4, wv4, wc4);
      end
    end
    @(negedge clock);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step4(1'b1, (r == 0 && c == 0), pix(8'h40, r, c));
        ev = (r >= 2 && c >= 2);
        checks++;
        if (wv4 !== ev || wc4 !== 12'(c) || (ev && zc4 !== taps(8'h40, r, c))) begin
          errors++;
          $display("FAIL rstmid r=%0d c=%0d got wv=%b col=%0d z=%h exp wv=%b col=%0d z=%h",
                   r, c, wv4, wc4, zc4, ev, c, taps(8'h40, r, c));
        end
      end
    end
  endtask

  task automatic test_width3();
    logic ev;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        step3(1'b1, (r == 0 && c == 0), pix(0, r, c));
        ev = (r >= 2 && c == 2);
        checks++;
        if (wv3 !== ev || wc3 !== 12'(c) || (ev && zc3 !== taps(0, r, c))) begin
          errors++;
          $display("FAIL w3 r=%0d c=%0d got wv=%b col=%0d z=%h exp wv=%b col=%0d z=%h",
                   r, c, wv3, wc3, zc3, ev, c, taps(0, r, c));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stalls();
    test_midframe_sof();
    test_reset_midframe();
    test_width3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
